// File: rtl/serial_ripple_borrow_sub.sv
// Serial ripple-borrow subtractor: diff = a - b - bin, DIGIT bits per clock.
// Borrow is carried between cycles, LSB digit first.
module serial_ripple_borrow_sub #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic [CW-1:0]    cnt;
  logic             brw, bout_q;
  logic [DIGIT-1:0] ad, bd;
  logic [DIGIT:0]   sub;
  logic             last;

  assign ad   = a_q[int'(cnt)*DIGIT +: DIGIT];
  assign bd   = b_q[int'(cnt)*DIGIT +: DIGIT];
  // Extra top bit of the widened difference is the digit borrow-out.
  assign sub  = {1'b0, ad} - {1'b0, bd}
              - {{DIGIT{1'b0}}, brw};
  assign last = (cnt == CW'(N - 1));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == IDLE): if (in_valid)  state_nx = RUN;
      (state == RUN):  if (last)      state_nx = DONE;
      (state == DONE): if (out_ready) state_nx = IDLE;
      default:                        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      cnt    <= '0;
      brw    <= 1'b0;
      bout_q <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        a_q    <= a;
        b_q    <= b;
        brw    <= bin;
        diff_q <= '0;
        cnt    <= '0;
        bout_q <= 1'b0;
      end
    end else if (state == RUN) begin
      diff_q[int'(cnt)*DIGIT +: DIGIT] <= sub[DIGIT-1:0];
      brw <= sub[DIGIT];
      cnt <= cnt + 1'b1;
      if (last) begin
        bout_q <= sub[DIGIT];
        cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_serial_ripple_borrow_sub.sv
// Scoreboard bench for serial_ripple_borrow_sub.
// Instances at DIGIT=4, 1 and 32 share operands and reset.
module tb_serial_ripple_borrow_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic        bin;
  logic [2:0]  ivld, irdy, ovld, ordy, bo;
  logic [2:0][31:0] dif;

  logic [32:0] sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_ripple_borrow_sub #(.WIDTH(32), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(ivld[0]), .in_ready(irdy[0]),
    .a(a), .b(b), .bin(bin),
    .out_valid(ovld[0]), .out_ready(ordy[0]),
    .diff(dif[0]), .bout(bo[0])
  );

  serial_ripple_borrow_sub #(.WIDTH(32), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(ivld[1]), .in_ready(irdy[1]),
    .a(a), .b(b), .bin(bin),
    .out_valid(ovld[1]), .out_ready(ordy[1]),
    .diff(dif[1]), .bout(bo[1])
  );

  serial_ripple_borrow_sub #(.WIDTH(32), .DIGIT(32)) u_d32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(ivld[2]), .in_ready(irdy[2]),
    .a(a), .b(b), .bin(bin),
    .out_valid(ovld[2]), .out_ready(ordy[2]),
    .diff(dif[2]), .bout(bo[2])
  );

  function automatic logic [32:0] model(
    input logic [31:0] av, input logic [31:0] bv,
    input logic bi);
    return {1'b0, av} - {1'b0, bv} - {32'd0, bi};
  endfunction

  task automatic start_op(input int u, input logic [31:0] av,
                          input logic [31:0] bv, input logic bi);
    int g;
    g = 0;
    @(negedge clk);
    while (!irdy[u] && g < 100) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (!irdy[u]) begin
      errors++;
      $display("FAIL accept_timeout u=%0d in_ready=%b want 1", u, irdy[u]);
    end
    a = av; b = bv; bin = bi;
    ivld[u] = 1'b1;
    sb.push_back(model(av, bv, bi));
    @(posedge clk);
    #1 ivld[u] = 1'b0;
  endtask

  task automatic wait_done(input int u, output int lat);
    lat = 0;
    while (!ovld[u] && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic release_out(input int u);
    ordy[u] = 1'b1;
    @(posedge clk);
    #1 ordy[u] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (irdy[u] !== 1'b1 || ovld[u] !== 1'b0) begin
        errors++;
        $display("FAIL reset_hs u=%0d in_ready=%b out_valid=%b want 1/0",
                 u, irdy[u], ovld[u]);
      end
      checks++;
      if ({bo[u], dif[u]} !== 33'd0) begin
        errors++;
        $display("FAIL reset_data u=%0d got %h want 0", u, {bo[u], dif[u]});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    logic [32:0] e;
    start_op(0, 32'd5, 32'd3, 1'b0);
    checks++;
    if (irdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL run_in_ready got %b want 0", irdy[0]);
    end
    wait_done(0, lat);
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL latency got %0d want 8", lat);
    end
    e = sb.pop_front();
    checks++;
    if ({bo[0], dif[0]} !== e) begin
      errors++;
      $display("FAIL basic got %h want %h", {bo[0], dif[0]}, e);
    end
    release_out(0);
  endtask

  task automatic test_wrap();
    logic [31:0] ta[5] = '{32'h0, 32'h12345678, 32'h80000000,
                           32'h0, 32'h7};
    logic [31:0] tb_[5] = '{32'h1, 32'h12345678, 32'h1,
                            32'hFFFFFFFF, 32'h7};
    logic tbi[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [32:0] want[5] = '{33'h1FFFFFFFF, 33'h1FFFFFFFF,
                             33'h07FFFFFFF, 33'h100000000,
                             33'h000000000};
    int lat;
    logic [32:0] e;
    for (int i = 0; i < 5; i++) begin
      start_op(0, ta[i], tb_[i], tbi[i]);
      wait_done(0, lat);
      e = sb.pop_front();
      checks++;
      if ({bo[0], dif[0]} !== want[i] || e !== want[i]) begin
        errors++;
        $display("FAIL wrap%0d got %h want %h", i, {bo[0], dif[0]}, want[i]);
      end
      release_out(0);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [32:0] e;
    start_op(0, 32'hDEAD0000, 32'h0000BEEF, 1'b1);
    wait_done(0, lat);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (ovld[0] !== 1'b1 || irdy[0] !== 1'b0 ||
          {bo[0], dif[0]} !== e) begin
        errors++;
        $display("FAIL hold%0d vld=%b rdy=%b got %h want 1/0/%h",
                 i, ovld[0], irdy[0], {bo[0], dif[0]}, e);
      end
    end
    release_out(0);
    checks++;
    if (irdy[0] !== 1'b1 || ovld[0] !== 1'b0) begin
      errors++;
      $display("FAIL release in_ready=%b out_valid=%b want 1/0",
               irdy[0], ovld[0]);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [32:0] e;
    start_op(0, 32'hFFFF0000, 32'h0000FFFF, 1'b0);
    void'(sb.pop_back());
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (dif[0] !== 32'h00000001) begin
      errors++;
      $display("FAIL partial got %h want 00000001", dif[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ovld[0] !== 1'b0 || irdy[0] !== 1'b1 || dif[0] !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset vld=%b rdy=%b diff=%h want 0/1/0",
               ovld[0], irdy[0], dif[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_op(0, 32'd100, 32'd58, 1'b0);
    wait_done(0, lat);
    e = sb.pop_front();
    checks++;
    if ({bo[0], dif[0]} !== 33'd42 || e !== 33'd42) begin
      errors++;
      $display("FAIL after_reset got %h want 02a", {bo[0], dif[0]});
    end
    release_out(0);
  endtask

  task automatic test_random(input int u, input int nops);
    int sent, got, cyc;
    bit pend;
    logic [32:0] e;
    sent = 0; got = 0; cyc = 0; pend = 0;
    while (got < nops && cyc < nops * 60 + 100) begin
      @(negedge clk);
      cyc++;
      ordy[u] = ($urandom_range(0, 3) != 0);
      if (ovld[u] && ordy[u]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rand_extra u=%0d got %h want none",
                   u, {bo[u], dif[u]});
        end else begin
          e = sb.pop_front();
          if ({bo[u], dif[u]} !== e) begin
            errors++;
            $display("FAIL rand u=%0d got %h want %h",
                     u, {bo[u], dif[u]}, e);
          end
        end
        got++;
      end
      if (!pend && sent < nops) begin
        a = $urandom;
        b = ($urandom_range(0, 7) == 0) ? a : $urandom;
        bin = $urandom_range(0, 1) == 1;
        ivld[u] = 1'b1;
        pend = 1;
      end else if (!pend) begin
        ivld[u] = 1'b0;
      end
      if (pend && irdy[u]) begin
        sb.push_back(model(a, b, bin));
        sent++;
        pend = 0;
      end
    end
    @(negedge clk);
    ivld[u] = 1'b0;
    ordy[u] = 1'b0;
    checks++;
    if (got != nops || sb.size() != 0) begin
      errors++;
      $display("FAIL rand_count u=%0d got %0d left %0d want %0d/0",
               u, got, sb.size(), nops);
    end
    sb.delete();
  endtask

  initial begin
    ivld = '0; ordy = '0;
    a = '0; b = '0; bin = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_random(0, 2000);
    test_random(1, 500);
    test_random(2, 2000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
